l1_cache_ctrl: RTL and testbench
================================

Name: l1_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the CPU load/store port and the shared L2.
- Serves CPU word reads and writes from 64 lines × 4 words.
- Refills a missing line with four word-serial L2 reads and forwards every write to L2.
- Honours the L2 flush request by invalidating all lines.

Parameters:
- N, 32, data word width.
- LINES, 64, number of cache lines (index width 6).
- WORDS, 4, words per line (offset width 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cpu_addr  in  15  word address: tag [14:8], index [7:2], offset [1:0]
- cpu_wdata  in  N  store data
- cpu_read  in  1  load request, single-cycle pulse, sampled only in IDLE
- cpu_write  in  1  store request, single-cycle pulse, sampled only in IDLE; cpu_read wins if both high
- cpu_rdata  out  N  load data, valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  high whenever state != IDLE
- l2_addr  out  15  word address to L2
- l2_wdata  out  N  write data to L2
- l2_read_req  out  1  L2 read request
- l2_write_req  out  1  L2 write request
- l2_rdata  in  N  word returned by L2
- l2_busy  in  1  L2 not idle
- flush  in  1  invalidate-all request from L2
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Values on reset:
  - all valid bits 0; state IDLE; cpu_done=0; cpu_rdata=0
  - l2_addr=0; l2_wdata=0; counters 0; flush_pend=0; refill count 0
  - tags and data are not reset
- Reset mid-transaction returns to IDLE immediately. Request outputs drop, and no line stays valid.
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESPOND.
- IDLE:
  - On cpu_read or cpu_write, register addr, wdata and op, then go to LOOKUP.
  - If flush_pend or flush is high, clear all valid bits in one cycle and clear flush_pend. The flush takes priority: a CPU request in that same cycle is accepted after the flush, on the next cycle.
- flush outside IDLE sets flush_pend. Pending flushes are serviced on the first IDLE cycle.
- LOOKUP (hit = valid[idx] && tag match):
  - Read hit: cpu_rdata <= line word; hit_count++; go to RESPOND. Read-hit latency is request edge + 2 cycles to cpu_done.
  - Read miss: miss_count++; refill count=0; l2_addr={tag,idx,2'b00}; go to RD_REQ.
  - Write hit: update the line word; hit_count++; go to WR_REQ.
  - Write miss: miss_count++; the line is untouched; go to WR_REQ.
  - In both write cases, l2_addr=registered addr and l2_wdata=registered wdata.
- L2 handshake (identical for reads and writes):
  - The request is high throughout *_REQ.
  - *_REQ advances to *_WAIT on the first cycle l2_busy=1.
  - In *_WAIT the request equals l2_busy (combinational). It therefore falls in the same cycle L2 returns to idle, which prevents L2 from restarting.
  - l2_addr and l2_wdata are held stable for the entire transaction.
  - Only one of l2_read_req and l2_write_req is ever high.
- RD_WAIT with l2_busy=0:
  - Store l2_rdata into line word [count]; count++.
  - If count was <3: l2_addr offset = count+1; go to RD_REQ.
  - Else: tag <= tag; valid <= 1; cpu_rdata <= word[requested offset], taking the just-captured l2_rdata when offset=3; go to RESPOND.
- WR_WAIT with l2_busy=0: go to RESPOND. A write is acknowledged only after L2 completes it.
- RESPOND: cpu_done=1 for exactly one cycle, then IDLE.
- Counters saturate at 16'hFFFF.
- A flush arriving during a refill does not abort it. The line becomes valid and is then invalidated by the pending flush before the next request is looked up.

Test Plan:
- After reset, cpu_read addr 15'h0104; L2 returns 11,22,33,44 → four L2 reads at 0x0104..0x0107, cpu_rdata=11, miss_count=1, cpu_done single pulse.
- Immediately cpu_read 15'h0106 → cpu_done 2 cycles after request, cpu_rdata=33, no L2 request, hit_count=1.
- cpu_write 15'h0105 data 0xDEAD → one L2 write to 0x0105 with 0xDEAD, held until l2_busy falls; then read 0x0105 hits with 0xDEAD.
- cpu_write 15'h7F00 (miss) → L2 write issued, miss_count++; subsequent read of 0x7F00 misses and refills.
- Hold l2_busy high 10 cycles in a refill word → request and l2_addr stable; request falls combinationally with l2_busy, with no duplicate L2 transaction.
- Pulse flush mid-refill, then read 0x0104 → refill completes, line invalidated in next IDLE, read misses again; assert reset during RD_WAIT → request low, cpu_busy=0 immediately.

Source files
------------

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-through/no-write-allocate L1: read hit done 2 cycles after request, misses refill 4 words.
// Backpressure: cpu_busy while not IDLE; L2 requests held until l2_busy rises, then track l2_busy.
module l1_cache_ctrl #(
    parameter int N     = 32,
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [14:0]   cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    input  logic          cpu_read,
    input  logic          cpu_write,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_busy,
    output logic [14:0]   l2_addr,
    output logic [N-1:0]  l2_wdata,
    output logic          l2_read_req,
    output logic          l2_write_req,
    input  logic [N-1:0]  l2_rdata,
    input  logic          l2_busy,
    input  logic          flush,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int OW = $clog2(WORDS);
    localparam int TW = 15 - IW - OW;
    localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESPOND} state_t;
    state_t state, next;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [N-1:0]     data [LINES*WORDS];

    logic [14:0]   addr_r;
    logic [N-1:0]  wdata_r;
    logic          op_rd;
    logic [OW-1:0] cnt;
    logic          flush_pend;
    logic          req_pend;

    logic [TW-1:0]    tag_r;
    logic [IW-1:0]    idx_r;
    logic [OW-1:0]    off_r;
    logic             hit;
    logic             flush_now;
    logic             data_we;
    logic             tag_we;
    logic [IW+OW-1:0] data_waddr;
    logic [N-1:0]     data_wval;

    assign tag_r     = addr_r[14:IW+OW];
    assign idx_r     = addr_r[IW+OW-1:OW];
    assign off_r     = addr_r[OW-1:0];
    assign hit       = valid[idx_r] && (tags[idx_r] == tag_r);
    assign flush_now = (state == IDLE) && (flush || flush_pend);
    assign cpu_done  = (state == RESPOND);
    assign cpu_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next         = state;
        l2_read_req  = 1'b0;
        l2_write_req = 1'b0;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_waddr   = {idx_r, off_r};
        data_wval    = wdata_r;
        case (state)
            IDLE:    if (!flush_now && (req_pend || cpu_read || cpu_write)) next = LOOKUP;
            LOOKUP: begin
                if (op_rd) begin
                    next = hit ? RESPOND : RD_REQ;
                end else begin
                    next    = WR_REQ;
                    data_we = hit;
                end
            end
            RD_REQ: begin
                l2_read_req = 1'b1;
                if (l2_busy) next = RD_WAIT;
            end
            // Request follows l2_busy so it drops in the same cycle L2 goes idle.
            RD_WAIT: begin
                l2_read_req = l2_busy;
                if (!l2_busy) begin
                    data_we    = 1'b1;
                    data_waddr = {idx_r, cnt};
                    data_wval  = l2_rdata;
                    tag_we     = (cnt == LAST);
                    next       = (cnt == LAST) ? RESPOND : RD_REQ;
                end
            end
            WR_REQ: begin
                l2_write_req = 1'b1;
                if (l2_busy) next = WR_WAIT;
            end
            WR_WAIT: begin
                l2_write_req = l2_busy;
                if (!l2_busy) next = RESPOND;
            end
            RESPOND: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tags[idx_r]      <= tag_r;
        if (data_we) data[data_waddr] <= data_wval;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            cpu_rdata  <= '0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
            req_pend   <= 1'b0;
            cnt        <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            op_rd      <= 1'b0;
        end else begin
            if (flush && state != IDLE) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    // A request arriving with a flush is parked and looked up one cycle later.
                    if (flush_now) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                        if (cpu_read || cpu_write) req_pend <= 1'b1;
                    end else if (req_pend) begin
                        req_pend <= 1'b0;
                    end
                    if ((cpu_read || cpu_write) && !(req_pend && !flush_now)) begin
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        op_rd   <= cpu_read;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    end else begin
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                    end
                    if (op_rd) begin
                        if (hit) begin
                            cpu_rdata <= data[{idx_r, off_r}];
                        end else begin
                            cnt     <= '0;
                            l2_addr <= {tag_r, idx_r, {OW{1'b0}}};
                        end
                    end else begin
                        l2_addr  <= addr_r;
                        l2_wdata <= wdata_r;
                    end
                end
                RD_WAIT: begin
                    if (!l2_busy) begin
                        cnt <= cnt + OW'(1);
                        if (cnt != LAST) begin
                            l2_addr[OW-1:0] <= cnt + OW'(1);
                        end else begin
                            valid[idx_r] <= 1'b1;
                            cpu_rdata    <= (off_r == LAST) ? l2_rdata : data[{idx_r, off_r}];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: table of CPU requests plus hand sequences for long L2 stalls, flushes and reset.
module tb_l1_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_busy;
    logic [14:0] l2_addr;
    logic [31:0] l2_wdata;
    logic        l2_read_req, l2_write_req;
    logic [31:0] l2_rdata;
    logic        l2_busy;
    logic        flush;
    logic [15:0] hit_count, miss_count;

    l1_cache_ctrl #(.N(32), .LINES(64), .WORDS(4)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_busy(cpu_busy), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_read_req(l2_read_req), .l2_write_req(l2_write_req), .l2_rdata(l2_rdata),
        .l2_busy(l2_busy), .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // L2 model: accepts a request when idle, stays busy l2_delay+1 cycles.
    typedef struct packed {logic wr; logic [14:0] addr; logic [31:0] wdata;} l2_txn_t;
    logic [31:0] l2_mem [0:32767];
    l2_txn_t     l2_log [$];
    int          l2_delay = 1;
    int          l2_cnt = 0;
    l2_txn_t     cur;
    int          proto_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            l2_busy = 1'b0;
        end else begin
            if (l2_read_req && l2_write_req) proto_err++;
            if (l2_busy) begin
                if ((cur.wr ? l2_write_req : l2_read_req) !== 1'b1 || l2_addr !== cur.addr ||
                    (cur.wr && l2_wdata !== cur.wdata)) proto_err++;
                if (l2_cnt == 0) begin
                    if (cur.wr) l2_mem[cur.addr] = cur.wdata;
                    else        l2_rdata = l2_mem[cur.addr];
                    l2_busy = 1'b0;
                    #1;
                    chk("req_falls_with_busy", {30'd0, l2_read_req, l2_write_req}, 32'd0);
                end else begin
                    l2_cnt--;
                end
            end else if (l2_read_req || l2_write_req) begin
                cur = '{wr: l2_write_req, addr: l2_addr, wdata: l2_wdata};
                l2_log.push_back(cur);
                l2_busy = 1'b1;
                l2_cnt  = l2_delay;
            end
        end
    end

    // Scoreboard of expected CPU completions.
    typedef struct {logic rd; logic [31:0] rdata;} exp_t;
    exp_t sb [$];
    int   drive_cyc = 0;
    int   done_cyc = 0;

    always @(negedge clk) begin
        if (!reset && cpu_done) begin
            exp_t e;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_done: got cpu_done=1 expected no completion");
            end else begin
                e = sb.pop_front();
                if (e.rd) chk("cpu_rdata", cpu_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic wr, input logic [14:0] a, input logic [31:0] d, input logic [31:0] exp);
        sb.push_back('{rd: !wr, rdata: exp});
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_read  = !wr;
        cpu_write = wr;
        drive_cyc = cyc;
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s_timeout: got no cpu_done expected completion within 300 cycles", nm);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic expect_refill(input string nm, input logic [14:0] a);
        chk({nm, "_l2_txns"}, 32'(l2_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < l2_log.size(); k++)
            chk({nm, "_l2_rd_addr"}, {16'd0, l2_log[k].wr, l2_log[k].addr}, {17'd0, a[14:2], k[1:0]});
    endtask

    task automatic expect_write(input string nm, input logic [14:0] a, input logic [31:0] d);
        chk({nm, "_l2_txns"}, 32'(l2_log.size()), 32'd1);
        if (l2_log.size() > 0) begin
            chk({nm, "_l2_wr_addr"}, {16'd0, l2_log[0].wr, l2_log[0].addr}, {16'd1, a});
            chk({nm, "_l2_wr_data"}, l2_log[0].wdata, d);
        end
    endtask

    typedef struct {logic wr; logic [14:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic hit;} vec_t;
    vec_t vecs [11];

    initial begin
        logic [15:0] h0, m0;
        for (int i = 0; i < 32768; i++) l2_mem[i] = 32'hA000_0000 | i;
        l2_mem[15'h0104] = 32'd11;
        l2_mem[15'h0105] = 32'd22;
        l2_mem[15'h0106] = 32'd33;
        l2_mem[15'h0107] = 32'd44;

        vecs[0]  = '{1'b0, 15'h0104, 32'h0,      32'd11,         1'b0};
        vecs[1]  = '{1'b0, 15'h0106, 32'h0,      32'd33,         1'b1};
        vecs[2]  = '{1'b1, 15'h0105, 32'hDEAD,   32'h0,          1'b1};
        vecs[3]  = '{1'b0, 15'h0105, 32'h0,      32'hDEAD,       1'b1};
        vecs[4]  = '{1'b1, 15'h7F00, 32'hBEEF,   32'h0,          1'b0};
        vecs[5]  = '{1'b0, 15'h7F00, 32'h0,      32'hBEEF,       1'b0};
        vecs[6]  = '{1'b0, 15'h7F03, 32'h0,      32'hA0007F03,   1'b1};
        vecs[7]  = '{1'b0, 15'h0007, 32'h0,      32'hA0000007,   1'b0};
        vecs[8]  = '{1'b0, 15'h0104, 32'h0,      32'd11,         1'b0};
        vecs[9]  = '{1'b1, 15'h0000, 32'h1234,   32'h0,          1'b0};
        vecs[10] = '{1'b0, 15'h7F01, 32'h0,      32'hA0007F01,   1'b1};

        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        flush = 1'b0; l2_busy = 1'b0; l2_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_done",  {31'd0, cpu_done}, 32'd0);
        chk("rst_cpu_busy",  {31'd0, cpu_busy}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_l2_addr",   {17'd0, l2_addr}, 32'd0);
        chk("rst_l2_wdata",  l2_wdata, 32'd0);
        chk("rst_l2_reqs",   {30'd0, l2_read_req, l2_write_req}, 32'd0);
        chk("rst_counters",  {hit_count, miss_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            l2_log.delete();
            h0 = hit_count;
            m0 = miss_count;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hit_delta", i),  {16'd0, hit_count - h0},  {31'd0, vecs[i].hit});
            chk($sformatf("vec%0d_miss_delta", i), {16'd0, miss_count - m0}, {31'd0, !vecs[i].hit});
            if (vecs[i].wr)
                expect_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata);
            else if (!vecs[i].hit)
                expect_refill($sformatf("vec%0d", i), vecs[i].addr);
            else begin
                chk($sformatf("vec%0d_no_l2", i), 32'(l2_log.size()), 32'd0);
                chk($sformatf("vec%0d_hit_latency", i), 32'(done_cyc - drive_cyc), 32'd2);
            end
        end

        // L2 stalls 10 cycles on every refill word.
        l2_delay = 9;
        l2_log.delete();
        issue(1'b0, 15'h0200, 32'h0, 32'hA0000200);
        wait_done("long_busy");
        expect_refill("long_busy", 15'h0200);
        l2_delay = 1;

        // Flush during a refill: the line completes, then is invalidated.
        l2_delay = 3;
        l2_log.delete();
        issue(1'b0, 15'h0300, 32'h0, 32'hA0000300);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done("flush_mid");
        expect_refill("flush_mid", 15'h0300);
        l2_delay = 1;
        l2_log.delete();
        m0 = miss_count;
        issue(1'b0, 15'h0300, 32'h0, 32'hA0000300);
        wait_done("after_flush");
        chk("after_flush_miss", {16'd0, miss_count - m0}, 32'd1);
        expect_refill("after_flush", 15'h0300);

        // Flush and request in the same IDLE cycle: request must see the cleared line.
        l2_log.delete();
        m0 = miss_count;
        flush = 1'b1;
        issue(1'b0, 15'h0301, 32'h0, 32'hA0000301);
        flush = 1'b0;
        wait_done("flush_req");
        chk("flush_req_miss", {16'd0, miss_count - m0}, 32'd1);
        expect_refill("flush_req", 15'h0301);

        // Reset while waiting on L2.
        l2_delay = 5;
        issue(1'b0, 15'h0500, 32'h0, 32'hA0000500);
        repeat (2) @(negedge clk);
        chk("pre_rst_in_wait", {30'd0, l2_read_req, l2_busy}, 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_read_req", {31'd0, l2_read_req}, 32'd0);
        chk("mid_rst_cpu_busy", {31'd0, cpu_busy}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        l2_delay = 1;
        chk("post_rst_counters", {hit_count, miss_count}, 32'd0);
        @(negedge clk);
        l2_log.delete();
        issue(1'b0, 15'h0104, 32'h0, 32'd11);
        wait_done("post_rst");
        chk("post_rst_miss", {16'd0, miss_count}, 32'd1);
        expect_refill("post_rst", 15'h0104);

        chk("l2_protocol", 32'(proto_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
